// File: rtl/servo_pkg.sv
// Shared defaults and helpers for the multi-channel servo PWM generator.
package servo_pkg;

  localparam int PERIOD_DEF = 1500;
  localparam int OFFSET_DEF = 75;
  localparam int W_W_DEF    = 8;

  // Adds a and b, clamping the sum to limit so a pulse never exceeds the frame.
  function automatic int sat_add(input int a, input int b, input int limit);
    int sum;
    sum = a + b;
    return (sum > limit) ? limit : sum;
  endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo channel: pending/active command registers, frame-latched enable,
// pulse comparator and registered output.
// Optional slew limiting of the active command is enabled by SERVO_SLEW_EN.
module servo_pwm_chan
  import servo_pkg::*;
#(
  parameter int CNT_W  = 13,
  parameter int PERIOD = PERIOD_DEF,
  parameter int W_W    = W_W_DEF,
  parameter int OFFSET = OFFSET_DEF
`ifdef SERVO_SLEW_EN
  ,
  parameter int SLEW_STEP = 4
`endif
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             frame_wrap,
  input  logic             wr_sel,
  input  logic [W_W-1:0]   wr_data,
  input  logic             ch_en,
  input  logic [CNT_W-1:0] counter,
  output logic             pwmout
);

  localparam int HI_W = CNT_W + 1;

  logic [W_W-1:0] pending;
  logic [W_W-1:0] active;
  logic [W_W-1:0] target;
  logic [W_W-1:0] active_next;
  logic           en_lat;
  logic [HI_W-1:0] hi;

  // A write landing in the wrap cycle must reach active, so forward it here.
  always_comb begin
    target = wr_sel ? wr_data : pending;
  end

`ifdef SERVO_SLEW_EN
  // Step active toward the target by at most SLEW_STEP, snapping when close.
  always_comb begin
    active_next = target;
    if (target > active) begin
      if (int'(target - active) > SLEW_STEP) begin
        active_next = active + W_W'(SLEW_STEP);
      end
    end else if (int'(active - target) > SLEW_STEP) begin
      active_next = active - W_W'(SLEW_STEP);
    end
  end
`else
  // Without slew limiting the new frame takes the target directly.
  always_comb begin
    active_next = target;
  end
`endif

  // Pulse length in cycles, never longer than the frame itself.
  always_comb begin
    hi = HI_W'(sat_add(OFFSET, int'(active), PERIOD));
  end

  // Hold the most recent command until the next frame boundary.
  always_ff @(posedge clkin or posedge rstn) begin
    if (rstn) begin
      pending <= '0;
    end else if (wr_sel) begin
      pending <= wr_data;
    end
  end

  // Command and enable only change at the wrap so pulses are never cut short.
  always_ff @(posedge clkin or posedge rstn) begin
    if (rstn) begin
      active <= '0;
      en_lat <= 1'b0;
    end else if (frame_wrap) begin
      active <= active_next;
      en_lat <= ch_en;
    end
  end

  // Registered output keeps the pin free of comparator glitches.
  always_ff @(posedge clkin or posedge rstn) begin
    if (rstn) begin
      pwmout <= 1'b0;
    end else begin
      pwmout <= en_lat && ({1'b0, counter} < hi);
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: one shared frame counter drives CH_NUM
// channels whose commands are written through a simple strobe/ack port.
// Define SERVO_SLEW_EN to limit how fast each channel's command may move.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int CH_NUM    = 4,
  parameter int CNT_W     = 13,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int W_W       = W_W_DEF,
  parameter int OFFSET    = OFFSET_DEF,
  parameter int SLEW_STEP = 4,
  localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [W_W-1:0]    wr_data,
  output logic              wr_ack,
  input  logic [CH_NUM-1:0] ch_en,
  output logic              frame_tick,
  output logic [CH_NUM-1:0] pwmout
);

  logic [CNT_W-1:0] counter;
  logic             frame_wrap;
  logic             wr_valid;

  if (CH_NUM < 1 || CH_NUM > 16 || PERIOD >= (1 << CNT_W) || SLEW_STEP < 1) begin : g_param_check
    $error("servo_pwm_multi: illegal parameter combination");
  end

  assign frame_wrap = (counter == CNT_W'(PERIOD - 1));
  assign wr_valid   = wr_en && (int'({1'b0, wr_ch}) < CH_NUM);

  // Free-running frame counter, 0..PERIOD-1.
  always_ff @(posedge clkin or posedge rstn) begin
    if (rstn) begin
      counter <= '0;
    end else if (frame_wrap) begin
      counter <= '0;
    end else begin
      counter <= counter + CNT_W'(1);
    end
  end

  // Frame tick lines up with counter==0; ack follows an accepted write.
  always_ff @(posedge clkin or posedge rstn) begin
    if (rstn) begin
      frame_tick <= 1'b0;
      wr_ack     <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      wr_ack     <= wr_valid;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    servo_pwm_chan #(
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .W_W       (W_W),
      .OFFSET    (OFFSET)
`ifdef SERVO_SLEW_EN
      ,
      .SLEW_STEP (SLEW_STEP)
`endif
    ) u_chan (
      .clkin      (clkin),
      .rstn       (rstn),
      .frame_wrap (frame_wrap),
      .wr_sel     (wr_valid && (int'({1'b0, wr_ch}) == i)),
      .wr_data    (wr_data),
      .ch_en      (ch_en[i]),
      .counter    (counter),
      .pwmout     (pwmout[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: directed scenarios plus random
// writes and enables, compared every cycle against a frame-level model.
module tb_servo_pwm_multi;

  localparam int CH_NUM    = 5;
  localparam int CNT_W     = 13;
  localparam int PERIOD    = 300;
  localparam int W_W       = 8;
  localparam int OFFSET    = 75;
  localparam int SLEW_STEP = 4;
  localparam int CHW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic              clkin = 1'b0;
  logic              rstn;
  logic              wr_en;
  logic [CHW-1:0]    wr_ch;
  logic [W_W-1:0]    wr_data;
  logic              wr_ack;
  logic [CH_NUM-1:0] ch_en;
  logic              frame_tick;
  logic [CH_NUM-1:0] pwmout;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: counter position, commands and per-frame pulse lengths.
  int   cnt_m;
  logic tick_m;
  logic ack_m;
  int   pending_m [CH_NUM];
  int   active_m  [CH_NUM];
  int   hi_cur    [CH_NUM];
  int   hi_prev   [CH_NUM];

  servo_pwm_multi #(
    .CH_NUM    (CH_NUM),
    .CNT_W     (CNT_W),
    .PERIOD    (PERIOD),
    .W_W       (W_W),
    .OFFSET    (OFFSET),
    .SLEW_STEP (SLEW_STEP)
  ) dut (
    .clkin      (clkin),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .ch_en      (ch_en),
    .frame_tick (frame_tick),
    .pwmout     (pwmout)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      $error("[TB] %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Command a channel ends up with this cycle, including a same-cycle write.
  function automatic int target_of(input int i);
    if (wr_en && int'(wr_ch) == i) return int'(wr_data);
    return pending_m[i];
  endfunction

  // How far the active command moves toward its target in one frame.
  function automatic int step_toward(input int act, input int tgt);
`ifdef SERVO_SLEW_EN
    if (tgt > act + SLEW_STEP) return act + SLEW_STEP;
    if (tgt < act - SLEW_STEP) return act - SLEW_STEP;
    return tgt;
`else
    return tgt;
`endif
  endfunction

  function automatic int pulse_len(input logic en, input int act);
    if (!en) return 0;
    return (OFFSET + act > PERIOD) ? PERIOD : OFFSET + act;
  endfunction

  // Output seen during the cycle where the counter reads cnt_m (one cycle of lag).
  function automatic logic [CH_NUM-1:0] expected_pwm();
    logic [CH_NUM-1:0] v;
    v = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cnt_m == 0) v[i] = (hi_prev[i] >= PERIOD);
      else            v[i] = ((cnt_m - 1) < hi_cur[i]);
    end
    return v;
  endfunction

  // Model advances on the same edges as the design.
  always @(posedge clkin or posedge rstn) begin
    if (rstn) begin
      cnt_m  <= 0;
      tick_m <= 1'b0;
      ack_m  <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        pending_m[i] <= 0;
        active_m[i]  <= 0;
        hi_cur[i]    <= 0;
        hi_prev[i]   <= 0;
      end
    end else begin
      ack_m <= wr_en && (int'(wr_ch) < CH_NUM);
      for (int i = 0; i < CH_NUM; i++) pending_m[i] <= target_of(i);
      if (cnt_m == PERIOD - 1) begin
        cnt_m  <= 0;
        tick_m <= 1'b1;
        for (int i = 0; i < CH_NUM; i++) begin
          active_m[i] <= step_toward(active_m[i], target_of(i));
          hi_cur[i]   <= pulse_len(ch_en[i], step_toward(active_m[i], target_of(i)));
          hi_prev[i]  <= hi_cur[i];
        end
      end else begin
        cnt_m  <= cnt_m + 1;
        tick_m <= 1'b0;
      end
    end
  end

  // Compare every output on the falling edge while out of reset.
  always @(negedge clkin) begin
    if (!rstn) begin
      check("pwmout", 32'(pwmout), 32'(expected_pwm()));
      check("frame_tick", 32'(frame_tick), 32'(tick_m));
      check("wr_ack", 32'(wr_ack), 32'(ack_m));
    end
  end

  task automatic do_write(input int ch, input int data);
    wr_en   = 1'b1;
    wr_ch   = CHW'(ch);
    wr_data = W_W'(data);
    @(negedge clkin);
    wr_en   = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    for (int n = 0; n < 3 * PERIOD; n++) begin
      @(negedge clkin);
      if (cnt_m == target) return;
    end
    total_cnt++;
    fail_cnt++;
    $display("[TB] FAIL wait_cnt: counter never reached %0d", target);
  endtask

  task automatic run_frames(input int n);
    repeat (n * PERIOD) @(negedge clkin);
  endtask

  initial begin
    rstn    = 1'b1;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_data = '0;
    ch_en   = '1;
    #1;
    check("reset_pwmout", 32'(pwmout), 32'd0);
    check("reset_tick", 32'(frame_tick), 32'd0);
    check("reset_ack", 32'(wr_ack), 32'd0);
    #20;
    check("reset_held_pwmout", 32'(pwmout), 32'd0);
    #1 rstn = 1'b0;

    $display("[TB] idle frames, all channels at minimum pulse");
    run_frames(3);

    $display("[TB] mid-frame write ch2=100");
    wait_cnt(100);
    do_write(2, 100);
    check("ack_ch2", 32'(wr_ack), 32'd1);
    run_frames(3);

    $display("[TB] saturating write ch1=255");
    wait_cnt(50);
    do_write(1, 255);
    run_frames(3);

    $display("[TB] write in wrap cycle ch0=50");
    wait_cnt(PERIOD - 1);
    do_write(0, 50);
    run_frames(2);

    $display("[TB] out-of-range channel write");
    wait_cnt(10);
    do_write(7, 200);
    check("ack_invalid", 32'(wr_ack), 32'd0);
    run_frames(2);

    $display("[TB] random writes and enables");
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(1, 80)) @(negedge clkin);
      if ($urandom_range(0, 4) == 0) ch_en = CH_NUM'($urandom);
      do_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    end
    ch_en = '1;
    run_frames(2);

    $display("[TB] disable ch3 mid-pulse");
    wait_cnt(20);
    ch_en[3] = 1'b0;
    run_frames(2);

    $display("[TB] asynchronous reset mid-pulse");
    wait_cnt(40);
    check("pre_reset_pwm0", 32'(pwmout[0]), 32'd1);
    #2 rstn = 1'b1;
    #1;
    check("async_pwmout", 32'(pwmout), 32'd0);
    check("async_tick", 32'(frame_tick), 32'd0);
    check("async_ack", 32'(wr_ack), 32'd0);
    repeat (3) @(negedge clkin);
    #2 rstn = 1'b0;
    ch_en = '1;
    run_frames(2);

    $display("[TB] command step 0 -> 20 on ch0");
    wait_cnt(30);
    do_write(0, 0);
    run_frames(1);
    do_write(0, 20);
    run_frames(7);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
- Multi-channel, parametrised successor to the single-channel servo PWM generator.
- One free-running frame counter is shared by CH_NUM pulse outputs.
- Each channel's pulse width is written through a simple write port, held in a pending register, and applied only at a frame boundary, so the outputs are glitch-free.
- Sits between the command/UART decode logic and the servo output pins.

Parameters:
- CH_NUM, 4, number of servo channels (1..16).
- CNT_W, 13, frame counter width.
- PERIOD, 1500, frame length in clkin cycles; counter runs 0..PERIOD-1; must satisfy PERIOD < 2**CNT_W.
- W_W, 8, width of the written pulse-width command.
- OFFSET, 75, constant cycles added to every command (minimum pulse).
- SLEW_STEP, 4, maximum change of the active command per frame; used only with SERVO_SLEW_EN.

Ports:
- clkin  in  1  system clock.
- rstn  in  1  asynchronous, active-high reset (asserted = 1), despite the name.
- wr_en  in  1  write strobe, single cycle.
- wr_ch  in  max(1,$clog2(CH_NUM))  target channel index.
- wr_data  in  W_W  pulse-width command.
- wr_ack  out  1  one-cycle pulse acknowledging an accepted write.
- ch_en  in  CH_NUM  per-channel output enable.
- frame_tick  out  1  one-cycle pulse at frame start.
- pwmout  out  CH_NUM  servo pulse outputs.

Behaviour:
- Reset: rstn is asynchronous and active-high. While asserted, all of the following are 0 immediately and regardless of clkin:
  - counter, pending[], active[], en_lat[];
  - pwmout, frame_tick, wr_ack.
- Reset mid-pulse drives the output low at once. After release, the first frame starts at counter=0.
- Counter: increments each cycle. At counter==PERIOD-1 it wraps to 0 on the next edge. No other values are reachable.
- Frame boundary: defined as the cycle where counter==PERIOD-1 (wrap cycle). On that edge:
  - active[i] <= pending[i];
  - en_lat[i] <= ch_en[i];
  - frame_tick <= 1 for exactly one cycle, coincident with counter==0.
- Writes:
  - wr_en=1 with wr_ch<CH_NUM: pending[wr_ch] <= wr_data, and wr_ack=1 on the next cycle.
  - wr_ch>=CH_NUM: ignored, no ack.
  - Back-to-back writes are allowed every cycle; the last write to a channel before the wrap edge wins.
  - A write in the wrap cycle itself is forwarded: that data, not the old pending value, loads active.
- Pulse width:
  - hi[i] = OFFSET + active[i], computed at CNT_W+1 bits and saturated to PERIOD.
  - Output is registered: pwmout[i] <= en_lat[i] && (counter < hi[i]).
  - pwmout therefore lags the counter by 1 cycle.
  - A high pulse spans exactly hi[i] cycles per frame.
- Boundary cases:
  - hi=0: constant low.
  - hi=PERIOD: constant high, no low cycle.
  - A channel disabled mid-frame finishes the current frame unchanged; the change takes effect from the next frame.
- ch_en changes and writes never truncate or extend a pulse already in progress.

Optional Feature:
- Macro: SERVO_SLEW_EN.
- Defined: at each frame boundary, active[i] moves toward pending[i] by at most SLEW_STEP, without overshoot. If |pending-active| <= SLEW_STEP, active becomes equal to pending. The wrap-cycle write-forward rule still applies to the target value.
- Undefined: active[i] takes pending[i] directly. The SLEW_STEP parameter is unused.

Decomposition:
- Package servo_pkg:
  - default constants: PERIOD_DEF=1500, OFFSET_DEF=75, W_W_DEF=8;
  - a helper function for saturating add to PERIOD.
- Sub-module servo_pwm_chan:
  - contains the pending/active registers, optional slew logic, the comparator and the pwmout register;
  - instantiated CH_NUM times in a generate loop.
- Top level owns the counter, frame_tick, write decode and wr_ack.

Test Plan:
- Reset release, all ch_en=1, no writes -> frame_tick every 1500 cycles. Every pwmout high for exactly 75 cycles per frame, rising 1 cycle after counter=0.
- Write ch2=100 mid-frame -> wr_ack the next cycle. Current frame still 75 high cycles; the next frame ch2 is 175 high cycles. Other channels unchanged.
- Write ch1=255 with OFFSET=75 and PERIOD=300 override -> hi saturates to 300, pwmout[1] constantly high.
- Write issued in the wrap cycle (counter=1499), ch0=50 -> frame starting the next cycle has 125 high cycles. wr_ch=7 with CH_NUM=4 -> no ack, no change.
- Deassert ch_en[3] at counter=20 -> pulse completes to 75 cycles; pwmout[3] stays 0 from the next frame. Assert rstn at counter=40 -> all outputs 0 immediately; frame restarts after release.
- With SERVO_SLEW_EN, SLEW_STEP=4: write ch0=0->20 -> active sequence 4, 8, 12, 16, 20 over 5 frames (hi 79..95), then stable.
